// File: rtl/fetch_unit_if.sv
// fetch_unit_if: fetch-stage bundle shared by the fetch unit, instruction memory and decode.
// Ports: none.
// Signals:
//   mem_addr        - fetch address to instruction_memory
//   mem_instr       - registered memory read data for the previous address
//   stall           - decode cannot accept this cycle
//   redirect_valid  - external PC redirect request
//   redirect_target - new fetch PC for a redirect
//   if_valid        - if_instr/if_pc are valid
//   if_instr        - fetched instruction
//   if_pc           - address of if_instr
// Modports:
//   master - the fetch unit
//   slave  - memory/decode side
interface fetch_unit_if;
    logic [15:0] mem_addr;
    logic [15:0] mem_instr;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    modport master (
        output mem_addr, if_valid, if_instr, if_pc,
        input  mem_instr, stall, redirect_valid, redirect_target
    );
    modport slave (
        input  mem_addr, if_valid, if_instr, if_pc,
        output mem_instr, stall, redirect_valid, redirect_target
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with one-cycle memory latency tracking, stall hold buffer, early JMP and redirect.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   f     - fetch_unit_if.master (memory address/data, decode handshake, redirect)
module fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] PC_STEP    = 16'd2,
    parameter logic [3:0]  JMP_OPCODE = 4'b0110
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master f
);
    logic [15:0] fpc, inflight_pc, hold_instr, hold_pc, jmp_tgt;
    logic        inflight_v, hold_v, out_v, consumed, is_jmp;

    // The hold buffer, when occupied, shadows the memory output.
    assign out_v      = hold_v | inflight_v;
    assign f.mem_addr = fpc;
    assign f.if_valid = out_v & ~f.redirect_valid;
    assign f.if_instr = hold_v ? hold_instr : f.mem_instr;
    assign f.if_pc    = hold_v ? hold_pc : inflight_pc;
    assign consumed   = f.if_valid & ~f.stall;
    assign is_jmp     = f.if_instr[15:12] == JMP_OPCODE;
    assign jmp_tgt    = f.if_pc + {{4{f.if_instr[11]}}, f.if_instr[11:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc         <= RESET_PC;
            inflight_v  <= 1'b0;
            inflight_pc <= 16'h0000;
            hold_v      <= 1'b0;
            hold_instr  <= 16'h0000;
            hold_pc     <= 16'h0000;
        end else if (f.redirect_valid) begin
            fpc        <= f.redirect_target;
            inflight_v <= 1'b0;
            hold_v     <= 1'b0;
        end else if (consumed && is_jmp) begin
            fpc        <= jmp_tgt;
            inflight_v <= 1'b0;
            hold_v     <= 1'b0;
        end else if (!f.stall || !out_v) begin
            inflight_v  <= 1'b1;
            inflight_pc <= fpc;
            fpc         <= fpc + PC_STEP;
            hold_v      <= 1'b0;
        end else if (inflight_v) begin
            // Stalled with data arriving from memory: park it so it is not lost.
            hold_instr <= f.mem_instr;
            hold_pc    <= inflight_pc;
            hold_v     <= 1'b1;
            inflight_v <= 1'b0;
        end
    end
endmodule
